// File: rtl/debounce_event_arbiter.sv
// Per-channel switch debouncer feeding a round-robin, single-slot event queue.
// Define DEBOUNCE_RELEASE_EN to debounce falling edges too; otherwise releases are immediate.
module debounce_event_arbiter #(
  parameter int N          = 4,
  parameter int TICK_DIV   = 16,
  parameter int STABLE_CNT = 7
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N-1:0]         RAW,
  output logic [N-1:0]         CLEAN,
  output logic                 EVT_VALID,
  input  logic                 EVT_READY,
  output logic [$clog2(N)-1:0] EVT_ID,
  output logic                 EVT_TYPE,
  output logic                 OVERRUN
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(STABLE_CNT + 1);
  localparam int PW  = $clog2(TICK_DIV);
`ifdef DEBOUNCE_RELEASE_EN
  localparam bit RELEASE_EN = 1'b1;
`else
  localparam bit RELEASE_EN = 1'b0;
`endif

  logic [N-1:0]   sync1_q, sync2_q;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick;
  logic [CW-1:0]  cnt_q [N];
  logic [CW-1:0]  cnt_d [N];
  logic [N-1:0]   clean_q, clean_d;
  logic [N-1:0]   raise, raise_type;
  logic [N-1:0]   pend_q, pend_d, ptype_q, ptype_d;
  logic [N-1:0]   grant_oh;
  logic           evt_valid_q, evt_valid_d;
  logic [IDW-1:0] evt_id_q, evt_id_d;
  logic           evt_type_q, evt_type_d;
  logic           overrun_q, overrun_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           load, grant_any;
  logic [IDW-1:0] grant_id, idx_w;

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // A counter hitting STABLE_CNT-1 on a tick is the increment that reaches STABLE_CNT.
  always_comb begin
    clean_d    = clean_q;
    raise      = '0;
    raise_type = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!RELEASE_EN && !sync2_q[i] && clean_q[i]) begin
        clean_d[i] = 1'b0;
        cnt_d[i]   = '0;
        raise[i]   = 1'b1;
      end else if (tick) begin
        if (sync2_q[i] != clean_q[i]) begin
          if (cnt_q[i] == CW'(STABLE_CNT - 1)) begin
            clean_d[i]    = ~clean_q[i];
            cnt_d[i]      = '0;
            raise[i]      = 1'b1;
            raise_type[i] = ~clean_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    load      = !evt_valid_q || EVT_READY;
    grant_any = 1'b0;
    grant_id  = '0;
    idx_w     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_w = IDW'((32'(rr_ptr_q) + k) % N);
      if (!grant_any && pend_q[idx_w]) begin
        grant_any = 1'b1;
        grant_id  = idx_w;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      grant_oh[i] = load && grant_any && (grant_id == IDW'(i));
    end

    // A channel granted this edge keeps its new event pending without overrun.
    pend_d    = (pend_q & ~grant_oh) | raise;
    ptype_d   = (ptype_q & ~raise) | (raise_type & raise);
    overrun_d = overrun_q | (|(raise & pend_q & ~grant_oh));

    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_type_d  = evt_type_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      evt_valid_d = grant_any;
      if (grant_any) begin
        evt_id_d   = grant_id;
        evt_type_d = ptype_q[grant_id];
        rr_ptr_d   = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      presc_q     <= '0;
      clean_q     <= '0;
      pend_q      <= '0;
      ptype_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= 1'b0;
      overrun_q   <= 1'b0;
      rr_ptr_q    <= '0;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= RAW;
      sync2_q     <= sync1_q;
      presc_q     <= presc_d;
      clean_q     <= clean_d;
      pend_q      <= pend_d;
      ptype_q     <= ptype_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_type_q  <= evt_type_d;
      overrun_q   <= overrun_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign CLEAN     = clean_q;
  assign EVT_VALID = evt_valid_q;
  assign EVT_ID    = evt_id_q;
  assign EVT_TYPE  = evt_type_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Bench for debounce_event_arbiter: behavioural model compared every cycle plus directed scenarios.
module tb_debounce_event_arbiter;
  localparam int N = 4, TICK_DIV = 4, STABLE_CNT = 3;
`ifdef DEBOUNCE_RELEASE_EN
  localparam bit REL_DEB = 1'b1;
`else
  localparam bit REL_DEB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, evt_ready, evt_valid, evt_type, overrun;
  logic [N-1:0] raw, clean;
  logic [1:0]   evt_id;
  int checks = 0, failures = 0;
  int evc, k;

  always #5 clk = ~clk;

  debounce_event_arbiter #(.N(N), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT)) dut (
    .CLK(clk), .RST_N(rst_n), .RAW(raw), .CLEAN(clean), .EVT_VALID(evt_valid),
    .EVT_READY(evt_ready), .EVT_ID(evt_id), .EVT_TYPE(evt_type), .OVERRUN(overrun)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: state advanced at each rising edge from the rules directly.
  int  m_s1[N], m_s2[N], m_clean[N], m_cnt[N], m_pend[N], m_ptype[N];
  int  m_presc, m_valid, m_id, m_type, m_ovr, m_next;
  int  m_rs[N], m_rt[N];
  int  m_g;
  bit  m_started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_clean[c] = 0; m_cnt[c] = 0; m_pend[c] = 0; m_ptype[c] = 0;
      end
      m_presc = 0; m_valid = 0; m_id = 0; m_type = 0; m_ovr = 0; m_next = 0;
      m_started = 1'b1;
    end else begin
      for (int c = 0; c < N; c++) begin
        m_rs[c] = 0; m_rt[c] = 0;
        if (!REL_DEB && m_s2[c] == 0 && m_clean[c] == 1) begin
          m_clean[c] = 0; m_cnt[c] = 0; m_rs[c] = 1; m_rt[c] = 0;
        end else if (m_presc == TICK_DIV - 1) begin
          if (m_s2[c] != m_clean[c]) begin
            m_cnt[c] = m_cnt[c] + 1;
            if (m_cnt[c] == STABLE_CNT) begin
              m_clean[c] = 1 - m_clean[c]; m_cnt[c] = 0; m_rs[c] = 1; m_rt[c] = m_clean[c];
            end
          end else begin
            m_cnt[c] = 0;
          end
        end
      end
      m_g = -1;
      if (!m_valid || evt_ready) begin
        for (int j = 0; j < N; j++)
          if (m_g < 0 && m_pend[(m_next + j) % N]) m_g = (m_next + j) % N;
        if (m_g >= 0) begin
          m_valid = 1; m_id = m_g; m_type = m_ptype[m_g]; m_pend[m_g] = 0; m_next = (m_g + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
      for (int c = 0; c < N; c++) begin
        if (m_rs[c]) begin
          if (m_pend[c]) m_ovr = 1;
          m_pend[c] = 1; m_ptype[c] = m_rt[c];
        end
        m_s2[c] = m_s1[c]; m_s1[c] = int'(raw[c]);
      end
      m_presc = (m_presc + 1) % TICK_DIV;
    end
  end

  function automatic int model_clean();
    int v = 0;
    for (int c = 0; c < N; c++) v += m_clean[c] << c;
    return v;
  endfunction

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_clean", int'(clean), model_clean());
      chk("model_valid", int'(evt_valid), m_valid);
      chk("model_id", int'(evt_id), m_id);
      chk("model_type", int'(evt_type), m_type);
      chk("model_overrun", int'(overrun), m_ovr);
    end
  end

  task automatic wait_clean(input int ch, input int v, input int maxc, input string nm, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (int'(clean[ch]) != v && n < maxc);
    if (int'(clean[ch]) != v) chk(nm, int'(clean[ch]), v);
  endtask

  task automatic wait_valid(input int maxc, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!evt_valid && n < maxc);
    if (!evt_valid) chk(nm, int'(evt_valid), 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; raw = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; raw = '0; evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_clean", int'(clean), 0);
    chk("reset_valid", int'(evt_valid), 0);
    chk("reset_id", int'(evt_id), 0);
    chk("reset_overrun", int'(overrun), 0);

    // Single press latency and one-cycle event
    raw = 4'b0001;
    wait_clean(0, 1, 40, "press0_timeout", k);
    chk("press0_latency_10_16", int'(k >= 10 && k <= 16), 1);
    chk("press0_valid_not_yet", int'(evt_valid), 0);
    @(negedge clk);
    chk("press0_valid", int'(evt_valid), 1);
    chk("press0_id", int'(evt_id), 0);
    chk("press0_type", int'(evt_type), 1);
    @(negedge clk);
    chk("press0_valid_drop", int'(evt_valid), 0);

    // Bouncing channel 1: no change while toggling, one press after hold
    evc = 0;
    for (int ph = 0; ph < 8; ph++) begin
      raw[1] = (ph % 2 == 0);
      repeat (5) begin @(negedge clk); evc += int'(evt_valid); end
    end
    chk("bounce_no_event", evc, 0);
    chk("bounce_clean1_low", int'(clean[1]), 0);
    raw[1] = 1'b1;
    evc = 0;
    repeat (30) begin @(negedge clk); evc += int'(evt_valid); end
    chk("bounce_one_event", evc, 1);
    chk("bounce_clean1_high", int'(clean[1]), 1);

    // Simultaneous press then release bursts, pointer wraps
    do_reset();
    raw = 4'b1111;
    wait_valid(40, "burst_press_timeout");
    chk("burst_clean_all", int'(clean), 15);
    for (int i = 0; i < 4; i++) begin
      chk("burst_press_valid", int'(evt_valid), 1);
      chk("burst_press_id", int'(evt_id), i);
      chk("burst_press_type", int'(evt_type), 1);
      @(negedge clk);
    end
    chk("burst_press_end", int'(evt_valid), 0);
    raw = 4'b0000;
    wait_valid(40, "burst_rel_timeout");
    for (int i = 0; i < 4; i++) begin
      chk("burst_rel_valid", int'(evt_valid), 1);
      chk("burst_rel_id", int'(evt_id), i);
      chk("burst_rel_type", int'(evt_type), 0);
      @(negedge clk);
    end
    chk("burst_rel_end", int'(evt_valid), 0);

    // Stalled consumer: held event plus overwritten pending slot
    do_reset();
    raw = 4'b0100;
    wait_clean(2, 1, 40, "ovr_press_timeout", k);
    repeat (3) @(negedge clk);
    evt_ready = 1'b0; raw = 4'b0000;
    wait_valid(40, "ovr_rel_timeout");
    chk("ovr_held_id", int'(evt_id), 2);
    chk("ovr_held_type", int'(evt_type), 0);
    chk("ovr_not_yet", int'(overrun), 0);
    raw = 4'b0100;
    wait_clean(2, 1, 40, "ovr_press2_timeout", k);
    raw = 4'b0000;
    wait_clean(2, 0, 40, "ovr_rel2_timeout", k);
    repeat (2) @(negedge clk);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_hold_valid", int'(evt_valid), 1);
    chk("ovr_hold_id", int'(evt_id), 2);
    chk("ovr_hold_type", int'(evt_type), 0);
    evt_ready = 1'b1;
    @(negedge clk);
    chk("ovr_next_valid", int'(evt_valid), 1);
    chk("ovr_next_id", int'(evt_id), 2);
    chk("ovr_next_type", int'(evt_type), 0);
    @(negedge clk);
    chk("ovr_drained", int'(evt_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);

    // Reset while an event is held
    evt_ready = 1'b0; raw = 4'b0100;
    wait_clean(2, 1, 40, "rst_press_timeout", k);
    @(negedge clk);
    chk("rst_pre_valid", int'(evt_valid), 1);
    rst_n = 1'b0; raw = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_clean", int'(clean), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_type", int'(evt_type), 0);
    chk("rst_overrun", int'(overrun), 0);
    evc = 0;
    repeat (8) begin @(negedge clk); evc += int'(evt_valid); end
    chk("rst_no_replay", evc, 0);

    // Release path timing on channel 3
    evt_ready = 1'b1;
    do_reset();
    raw = 4'b1000;
    wait_clean(3, 1, 40, "rel3_press_timeout", k);
    repeat (3) @(negedge clk);
    raw = 4'b0000;
    wait_clean(3, 0, 40, "rel3_timeout", k);
    if (REL_DEB) chk("rel3_latency_10_16", int'(k >= 10 && k <= 16), 1);
    else         chk("rel3_latency", k, 3);
    @(negedge clk);
    chk("rel3_valid", int'(evt_valid), 1);
    chk("rel3_id", int'(evt_id), 3);
    chk("rel3_type", int'(evt_type), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debounce_event_arbiter.md
DEBOUNCE_EVENT_ARBITER -- requirements
Module: debounce_event_arbiter

Interface
REQ-001 Parameter N, default 4: number of switch channels; legal values 2..8.
REQ-002 Parameter TICK_DIV, default 16: clocks per debounce sample tick; minimum 2.
REQ-003 Parameter STABLE_CNT, default 7: consecutive agreeing ticks required to change a channel's CLEAN bit; legal values 1..15.
REQ-004 CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 RAW  in  N  asynchronous raw switch levels, 1 = pressed.
REQ-007 CLEAN  out  N  debounced, registered switch levels.
REQ-008 EVT_VALID  out  1  an event is presented on EVT_ID and EVT_TYPE.
REQ-009 EVT_READY  in  1  consumer accepts the event.
REQ-010 EVT_ID  out  clog2(N)  channel index of the presented event.
REQ-011 EVT_TYPE  out  1  1 = press (CLEAN rose), 0 = release (CLEAN fell).
REQ-012 OVERRUN  out  1  sticky flag: at least one event was overwritten before it was granted.

Function
REQ-013 Each RAW bit SHALL pass through a 2-flop synchronizer before use.
REQ-014 Prescaler: counts 0..TICK_DIV-1 and wraps; tick is high for exactly one cycle when the count equals TICK_DIV-1.
REQ-015 On each tick, per channel: if synced RAW != CLEAN, increment that channel's counter; else clear the counter to 0.
REQ-016 When an increment makes the counter reach STABLE_CNT: CLEAN toggles on that edge, the counter clears, and an event of the new CLEAN polarity is raised for that channel.
REQ-017 Counter width SHALL be clog2(STABLE_CNT+1); the counter never exceeds STABLE_CNT.
REQ-018 Each channel holds one pending slot (pending bit plus type), set on the edge its event is raised.
REQ-019 Output slot load: when (!EVT_VALID || EVT_READY) and any channel is pending, load the round-robin winner into EVT_ID/EVT_TYPE, set EVT_VALID, and clear the winner's pending bit, all on the same edge.
REQ-020 When EVT_VALID=1 and EVT_READY=0, EVT_VALID, EVT_ID and EVT_TYPE SHALL hold stable.
REQ-021 When EVT_READY=1 and nothing is pending, EVT_VALID SHALL drop on the next edge.
REQ-022 Round-robin: after a grant to channel i, priority starts at (i+1) mod N; back-to-back accepted grants give 1 event per cycle.
REQ-023 If a new event is raised for a channel whose pending bit is set and that channel is not being granted this edge, the slot is overwritten with the new type and OVERRUN sets.
REQ-024 If a new event is raised for a channel on the same edge that channel is granted, the old event is output, the new event stays pending, and OVERRUN is unaffected.
REQ-025 Events from different channels raised on the same edge SHALL all be retained as pending, with none lost.

Reset
REQ-026 When RST_N=0 at a clock edge: CLEAN=0, EVT_VALID=0, EVT_ID=0, EVT_TYPE=0, OVERRUN=0; all counters, the prescaler, pending bits and synchronizers clear to 0; the round-robin pointer gives channel 0 first priority.
REQ-027 Reset SHALL override EVT_READY and all in-flight activity; a held event is discarded without handshake.
REQ-028 OVERRUN SHALL clear only through reset.

Configuration
REQ-029 Macro DEBOUNCE_RELEASE_EN defined: falling transitions are debounced exactly as rising ones (REQ-015/016).
REQ-030 DEBOUNCE_RELEASE_EN undefined:
- When synced RAW=0 and CLEAN=1, CLEAN clears on the next edge regardless of tick.
- The counter clears on the same edge.
- A release event is raised on the same edge.
- Rising behaviour is unchanged.

Verification
REQ-031 N=4, TICK_DIV=4, STABLE_CNT=3; RAW[0] rises and is held, EVT_READY=1 -> CLEAN[0] rises 10..16 cycles later; one-cycle EVT_VALID with EVT_ID=0, EVT_TYPE=1.
REQ-032 RAW[1] toggles every 5 cycles for 40 cycles, then holds 1 -> no CLEAN[1] change and no event during toggling; exactly one press event after the hold.
REQ-033 RAW[0..3] rise on the same cycle with EVT_READY=1 -> four events on consecutive cycles with EVT_ID 0,1,2,3; a second simultaneous release burst yields 0,1,2,3 again (pointer wraps).
REQ-034 EVT_READY=0 while ch2 press then release complete -> OVERRUN=1; EVT_ID=2, EVT_TYPE=0 hold stable until EVT_READY=1.
REQ-035 RST_N=0 for one cycle while EVT_VALID=1 and EVT_READY=0 -> the next cycle shows all outputs 0 and no event is replayed.
REQ-036 DEBOUNCE_RELEASE_EN undefined, CLEAN[3]=1, RAW[3] falls -> CLEAN[3]=0 within 3 cycles (sync plus register), with a release event for ch3; with the macro defined, the same stimulus yields 10..16 cycles.
